// File: rtl/asynsc_fifo_pkg.sv
// Shared defaults and address-width helper for the single-clock FIFO.
package asynsc_fifo_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 16;

  // Pointer width for a power-of-two depth; never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/asynsc_fifo_mem.sv
// DEPTH x DATA_W register array: one write port, one registered read port.
module fifo_mem
  import asynsc_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW     = addr_w(DEPTH_DEF)
) (
  input  logic              clk_wt,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is not reset; only the read register is cleared.
  always_ff @(posedge clk_wt) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk_wt or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/asynsc_fifo.sv
// Single-clock FIFO: pointers, fill count and registered status flags around fifo_mem.
module asynsc_fifo
  import asynsc_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2
) (
  input  logic                      clk_wt,
  input  logic                      rst,
  input  logic                      we,
  input  logic                      re,
  input  logic [DATA_W-1:0]         din,
  output logic [DATA_W-1:0]         dout,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [addr_w(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int AW = addr_w(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          rd_acc;
  logic          wr_acc;
  logic [CW-1:0] count_nxt;

  // A read frees a slot in the same cycle, so a write at full is accepted alongside it.
  assign rd_acc = re && !empty;
  assign wr_acc = we && (!full || rd_acc);

  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk_wt or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + AW'(1);
      if (rd_acc) rptr <= rptr + AW'(1);
    end
  end

  // Flags are derived from the next count so they land on the same edge as count.
  always_ff @(posedge clk_wt or negedge rst) begin
    if (!rst) begin
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      count        <= count_nxt;
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == CW'(DEPTH));
      almost_empty <= (count_nxt <= CW'(AE_LVL));
      almost_full  <= (count_nxt >= CW'(AF_LVL));
      overflow     <= we && !wr_acc;
      underflow    <= re && !rd_acc;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk_wt (clk_wt),
    .rst    (rst),
    .we     (wr_acc),
    .waddr  (wptr),
    .wdata  (din),
    .re     (rd_acc),
    .raddr  (rptr),
    .rdata  (dout)
  );

endmodule

// File: tb/tb_asynsc_fifo.sv
// Self-checking bench for asynsc_fifo: directed table, corner sequences, random traffic vs queue model.
module tb_asynsc_fifo;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int AF     = DEPTH - 2;
  localparam int AE     = 2;

  logic              clk_wt = 1'b0;
  logic              rst;
  logic              we;
  logic              re;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              full, empty, almost_full, almost_empty;
  logic [4:0]        count;
  logic              overflow, underflow;

  int tests  = 0;
  int failed = 0;

  // Reference model: plain queue plus last value read.
  logic [DATA_W-1:0] q [$];
  logic [DATA_W-1:0] m_dout;
  logic              m_ov, m_un;

  typedef struct {
    logic              we;
    logic              re;
    logic [DATA_W-1:0] din;
    int                cnt;
    logic [DATA_W-1:0] dout;
    logic              full, empty, af, ae, ov, un;
  } vec_t;

  vec_t tbl [$];

  asynsc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_wt       (clk_wt),
    .rst          (rst),
    .we           (we),
    .re           (re),
    .din          (din),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk_wt = ~clk_wt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int cnt, input logic [DATA_W-1:0] d,
                           input logic f, input logic e, input logic af, input logic ae,
                           input logic ov, input logic un);
    chk({tag, ".count"}, 32'(count), cnt);
    chk({tag, ".dout"}, 32'(dout), 32'(d));
    chk({tag, ".full"}, 32'(full), 32'(f));
    chk({tag, ".empty"}, 32'(empty), 32'(e));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(af));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(ae));
    chk({tag, ".overflow"}, 32'(overflow), 32'(ov));
    chk({tag, ".underflow"}, 32'(underflow), 32'(un));
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_ov   = 1'b0;
    m_un   = 1'b0;
  endtask

  // Drive one cycle, advance the model by the acceptance rules, sample 1 ns after the edge.
  task automatic step(input logic w, input logic r, input logic [DATA_W-1:0] d);
    bit rd_ok, wr_ok;
    we  = w;
    re  = r;
    din = d;
    rd_ok = r && (q.size() > 0);
    wr_ok = w && ((q.size() < DEPTH) || rd_ok);
    @(posedge clk_wt);
    #1;
    if (rd_ok) m_dout = q.pop_front();
    if (wr_ok) q.push_back(d);
    m_ov = w && !wr_ok;
    m_un = r && !rd_ok;
    we = 1'b0;
    re = 1'b0;
  endtask

  task automatic check_model(input string tag);
    int n;
    n = q.size();
    check_all(tag, n, m_dout, n == DEPTH, n == 0, n >= AF, n <= AE, m_ov, m_un);
  endtask

  task automatic mstep(input string tag, input logic w, input logic r, input logic [DATA_W-1:0] d);
    step(w, r, d);
    check_model(tag);
  endtask

  function automatic vec_t mk(input logic w, input logic r, input logic [DATA_W-1:0] d,
                              input int cnt, input logic [DATA_W-1:0] o,
                              input logic ov, input logic un);
    vec_t v;
    v.we = w; v.re = r; v.din = d; v.cnt = cnt; v.dout = o;
    v.full = (cnt == DEPTH); v.empty = (cnt == 0);
    v.af = (cnt >= AF); v.ae = (cnt <= AE);
    v.ov = ov; v.un = un;
    return v;
  endfunction

  initial begin
    int pw, pr;
    logic [DATA_W-1:0] last;

    // Fill 0..15, overflow at full, drain 0..15, underflow on empty.
    for (int i = 0; i < 16; i++) tbl.push_back(mk(1'b1, 1'b0, DATA_W'(i), i + 1, '0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 16'hFFFF, 16, '0, 1'b1, 1'b0));
    for (int i = 0; i < 16; i++) tbl.push_back(mk(1'b0, 1'b1, '0, 15 - i, DATA_W'(i), 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, '0, 0, 16'd15, 1'b0, 1'b1));

    rst = 1'b0; we = 1'b0; re = 1'b0; din = '0;
    model_reset();
    repeat (3) @(posedge clk_wt);
    #1;
    check_all("reset", 0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk_wt);
    rst = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].we, tbl[i].re, tbl[i].din);
      check_all($sformatf("tbl%0d", i), tbl[i].cnt, tbl[i].dout, tbl[i].full, tbl[i].empty,
                tbl[i].af, tbl[i].ae, tbl[i].ov, tbl[i].un);
    end

    // Write on empty with a simultaneous read: no bypass.
    mstep("wr_on_empty", 1'b1, 1'b1, 16'h5A5A);
    chk("wr_on_empty.underflow_pulse", 32'(underflow), 32'd1);
    mstep("wr_on_empty.next", 1'b0, 1'b1, '0);
    chk("wr_on_empty.readback", 32'(dout), 32'h5A5A);

    // Simultaneous write and read at full: new word comes out last.
    for (int i = 0; i < DEPTH; i++) mstep("fill", 1'b1, 1'b0, DATA_W'(16'h100 + i));
    mstep("full_rw", 1'b1, 1'b1, 16'hABCD);
    chk("full_rw.count", 32'(count), 32'd16);
    chk("full_rw.no_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) mstep("drain", 1'b0, 1'b1, '0);
    chk("full_rw.last_word", 32'(dout), 32'hABCD);

    // Bursts of 10 in/10 out to carry the pointers around the array twice.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 10; i++) mstep("wrap_w", 1'b1, 1'b0, DATA_W'(16'h2000 + r * 16 + i));
      for (int i = 0; i < 10; i++) mstep("wrap_r", 1'b0, 1'b1, '0);
    end
    chk("wrap.empty", 32'(empty), 32'd1);

    // Random traffic in phases biased toward filling, draining, and balanced.
    for (int ph = 0; ph < 6; ph++) begin
      pw = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
      pr = 100 - pw;
      for (int i = 0; i < 250; i++)
        mstep("rand", $urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
              DATA_W'($urandom));
    end

    // Asynchronous reset mid-operation.
    model_reset();
    rst = 1'b0;
    @(negedge clk_wt);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) mstep("pre_rst", 1'b1, 1'b0, DATA_W'(16'h31 + i));
    mstep("pre_rst_rd", 1'b0, 1'b1, '0);
    last = dout;
    chk("pre_rst.dout", 32'(last), 32'h31);
    #2;
    rst = 1'b0;
    #1;
    check_all("async_rst", 0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    model_reset();
    @(negedge clk_wt);
    rst = 1'b1;
    mstep("post_rst_rd", 1'b0, 1'b1, '0);
    chk("post_rst.underflow", 32'(underflow), 32'd1);
    mstep("post_rst_rd2", 1'b0, 1'b1, '0);
    mstep("post_rst_wr", 1'b1, 1'b0, 16'h7777);
    mstep("post_rst_rdback", 1'b0, 1'b1, '0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/asynsc_fifo.md
ASYNSC_FIFO -- requirements
Module: asynsc_fifo

Interface
REQ-001 Parameter DATA_W, default 16, word width in bits.
REQ-002 Parameter DEPTH, default 16, number of entries; SHALL be a power of two, at least 4.
REQ-003 Parameter AF_LVL, default DEPTH-2, fill level at or above which almost_full asserts.
REQ-004 Parameter AE_LVL, default 2, fill level at or below which almost_empty asserts.
REQ-005 clk_wt  input  1  sole clock; write and read ports both sample on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 we  input  1  write request.
REQ-008 re  input  1  read request.
REQ-009 din  input  DATA_W  write data.
REQ-010 dout  output  DATA_W  registered read data.
REQ-011 full  output  1  count equals DEPTH.
REQ-012 empty  output  1  count equals 0.
REQ-013 almost_full  output  1  count >= AF_LVL.
REQ-014 almost_empty  output  1  count <= AE_LVL.
REQ-015 count  output  log2(DEPTH)+1  current fill level.
REQ-016 overflow  output  1  one-cycle pulse on a rejected write.
REQ-017 underflow  output  1  one-cycle pulse on a rejected read.

Function
REQ-018 The design SHALL be one clock domain: one clock, asynchronous active-low reset.
REQ-019 A read SHALL be accepted when re=1 and empty=0.
REQ-020 A write SHALL be accepted when we=1 and either full=0 or a read is accepted in the same cycle.
REQ-021 An accepted write SHALL store din at the write pointer and advance the pointer modulo DEPTH.
REQ-022 An accepted read SHALL load the entry at the read pointer into dout on the same edge, then advance the pointer modulo DEPTH.
REQ-023 Read latency SHALL be 1 cycle: data appears on dout after the edge that accepted the read.
REQ-024 dout SHALL hold its value when no read is accepted.
REQ-025 Write on empty SHALL have no bypass: a simultaneous re is rejected (underflow pulses), and the written word is readable from the next cycle.
REQ-026 count SHALL change as follows: +1 on write only, -1 on read only, unchanged when both are accepted.
REQ-027 full, empty, almost_full and almost_empty SHALL be registered and consistent with count in every cycle.
REQ-028 Data SHALL be returned in strict FIFO order, including across pointer wrap-around.
REQ-029 A rejected request SHALL leave storage, pointers and count unchanged.

Reset
REQ-030 While rst=0: pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, dout=0, overflow=0, underflow=0.
REQ-031 Reset asserted mid-operation SHALL discard all contents immediately; storage array contents need not be cleared.
REQ-032 Requests SHALL be honoured from the first rising edge after rst deasserts.

Structure
REQ-033 Package asynsc_fifo_pkg SHALL hold the DATA_W/DEPTH defaults and the derived address-width function.
REQ-034 Storage SHALL be a sub-module fifo_mem: a DEPTH x DATA_W register array with one write port and one registered read port.
REQ-035 Pointers, count and flags SHALL live in asynsc_fifo.

Verification
REQ-036 Reset, then write 0..15 on consecutive cycles -> full=1 after the 16th write, count=16, almost_full from count 14.
REQ-037 From full, write 0xFFFF -> overflow pulses for 1 cycle, count stays 16, contents unchanged.
REQ-038 From full, read 16 times -> dout = 0,1,...,15 each one cycle after its re; empty=1 at end; one further read -> underflow pulse, dout holds 15.
REQ-039 At full, assert we and re together -> both accepted, count stays 16, and the new word is read last.
REQ-040 Write 10 and read 10 with the pointers wrapping twice -> order preserved, empty=1 at end.
REQ-041 Assert rst after 5 writes -> count=0, empty=1, dout=0 asynchronously; subsequent reads underflow.
